// File: rtl/xadc_drp_responder.sv
// DRP slave that stands in for an XADC: a free-running four-channel sequencer
// publishes ramp codes in status-register layout, readable through a latency-matched DRP port.
module xadc_drp_responder #(
   parameter int CONV_CYCLES = 26,
   parameter int DRDY_LAT    = 4
) (
   input  logic        CLK100MHZ,
   input  logic        reset_in,
   input  logic [6:0]  daddr_in,
   input  logic        den_in,
   input  logic        dwe_in,
   input  logic [15:0] di_in,
   output logic [15:0] do_out,
   output logic        drdy_out,
   output logic        busy_out,
   output logic        eoc_out,
   output logic [4:0]  channel_out,
   output logic        drp_err_out
);

   // state  | meaning
   // S_IDLE | ready; den_in is accepted as a new request
   // S_WAIT | request in flight, counting down to the drdy pulse
   typedef enum logic {S_IDLE, S_WAIT} drp_state_t;

   localparam int TW = $clog2(CONV_CYCLES);
   localparam int LW = (DRDY_LAT > 1) ? $clog2(DRDY_LAT) : 1;
   localparam logic [TW-1:0] TC       = TW'(CONV_CYCLES - 1);
   localparam logic [LW-1:0] LAT_LOAD = LW'(DRDY_LAT - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(1);

   drp_state_t   r_state;
   logic [TW-1:0] r_timer;
   logic [1:0]   r_idx;
   logic [11:0]  r_code [4];
   logic [15:0]  r_cfg;
   logic [LW-1:0] r_cnt;
   logic [15:0]  r_rd_data;
   logic         r_is_rd;

   logic [15:0]  w_rdata;
   logic [4:0]   w_chan;
   logic [11:0]  w_step;
   logic         w_tc;
   logic         w_step_en;
   logic         w_cfg_wr;
   logic         w_hold_next;

   always_comb begin
      w_rdata = '0;
      case (daddr_in)
         7'h12:   w_rdata = {r_code[0], 4'h0};
         7'h13:   w_rdata = {r_code[1], 4'h0};
         7'h1A:   w_rdata = {r_code[2], 4'h0};
         7'h1B:   w_rdata = {r_code[3], 4'h0};
         7'h41:   w_rdata = r_cfg;
         default: w_rdata = '0;
      endcase
   end

   always_comb begin
      w_chan = 5'h12;
      case (r_idx)
         2'd0:    w_chan = 5'h12;
         2'd1:    w_chan = 5'h13;
         2'd2:    w_chan = 5'h1A;
         default: w_chan = 5'h1B;
      endcase
   end

   // channel k steps by 2^k, giving +1/+2/+4/+8 in sequence order
   assign w_step      = 12'd1 << r_idx;
   assign w_tc        = (r_timer == TC);
   assign w_step_en   = !r_cfg[0] && w_tc;
   assign w_cfg_wr    = (r_state == S_IDLE) && den_in && dwe_in && (daddr_in == 7'h41);
   // busy reflects the hold bit as it will stand in the next cycle
   assign w_hold_next = w_cfg_wr ? di_in[0] : r_cfg[0];

   always_ff @(posedge CLK100MHZ) begin
      if (reset_in) begin
         r_timer     <= '0;
         r_idx       <= '0;
         for (int i = 0; i < 4; i++) r_code[i] <= '0;
         eoc_out     <= 1'b0;
         channel_out <= '0;
         busy_out    <= 1'b0;
      end else begin
         eoc_out <= 1'b0;
         if (!r_cfg[0]) begin
            if (w_tc) begin
               r_timer        <= '0;
               r_code[r_idx]  <= r_code[r_idx] + w_step;
               r_idx          <= r_idx + 2'd1;
               eoc_out        <= 1'b1;
               channel_out    <= w_chan;
            end else begin
               r_timer <= r_timer + TW'(1);
            end
         end
         busy_out <= !w_hold_next && !w_step_en;
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (reset_in) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_rd_data   <= '0;
         r_is_rd     <= 1'b0;
         r_cfg       <= '0;
         do_out      <= '0;
         drdy_out    <= 1'b0;
         drp_err_out <= 1'b0;
      end else begin
         drdy_out <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (den_in) begin
                  r_rd_data <= w_rdata;
                  r_is_rd   <= !dwe_in;
                  if (w_cfg_wr) r_cfg <= di_in;
                  if (DRDY_LAT == 1) begin
                     drdy_out <= 1'b1;
                     if (!dwe_in) do_out <= w_rdata;
                  end else begin
                     r_cnt   <= LAT_LOAD;
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (den_in) drp_err_out <= 1'b1;
               r_cnt <= r_cnt - LW'(1);
               if (r_cnt == LAT_LAST) begin
                  drdy_out <= 1'b1;
                  if (r_is_rd) do_out <= r_rd_data;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Bench for xadc_drp_responder: directed sequences and a register table, with every
// cycle also compared against an arithmetic reference model of the sequencer and DRP port.
module tb_xadc_drp_responder;

   localparam int CONV = 26;
   localparam int LAT  = 4;

   logic        CLK100MHZ;
   logic        reset_in;
   logic [6:0]  daddr_in;
   logic        den_in;
   logic        dwe_in;
   logic [15:0] di_in;
   logic [15:0] do_out;
   logic        drdy_out;
   logic        busy_out;
   logic        eoc_out;
   logic [4:0]  channel_out;
   logic        drp_err_out;

   xadc_drp_responder #(.CONV_CYCLES(CONV), .DRDY_LAT(LAT)) dut (
      .CLK100MHZ  (CLK100MHZ),
      .reset_in   (reset_in),
      .daddr_in   (daddr_in),
      .den_in     (den_in),
      .dwe_in     (dwe_in),
      .di_in      (di_in),
      .do_out     (do_out),
      .drdy_out   (drdy_out),
      .busy_out   (busy_out),
      .eoc_out    (eoc_out),
      .channel_out(channel_out),
      .drp_err_out(drp_err_out)
   );

   initial begin
      CLK100MHZ = 1'b0;
      forever #5 CLK100MHZ = ~CLK100MHZ;
   end

   int n_cmp = 0;
   int n_bad = 0;
   int t_cyc = 0;
   int t_issue = 0;

   // ---------------- reference model ----------------
   // Conversion state is just the number of advancing cycles since reset;
   // each channel's code follows from how many conversions it has completed.
   int          m_run, m_cyc, m_free, m_due;
   logic        m_pend, m_prd, m_valid = 1'b0;
   logic        m_done, m_acc;
   logic [15:0] m_pval, m_cfg;
   logic [15:0] e_do;
   logic        e_drdy, e_busy, e_eoc, e_err;
   logic [4:0]  e_ch;

   function automatic logic [15:0] model_reg(input logic [6:0] a, input int run, input logic [15:0] cfg);
      int n, k, stp, cnt;
      logic [11:0] code;
      n = run / CONV;
      k = -1;
      case (a)
         7'h12: k = 0;
         7'h13: k = 1;
         7'h1A: k = 2;
         7'h1B: k = 3;
         default: k = -1;
      endcase
      if (a == 7'h41) return cfg;
      if (k < 0) return 16'h0000;
      stp  = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : 8;
      cnt  = (n + 3 - k) / 4;
      code = 12'((stp * cnt) % 4096);
      return {code, 4'h0};
   endfunction

   function automatic logic [4:0] model_chan(input int k);
      case (k)
         0: return 5'h12;
         1: return 5'h13;
         2: return 5'h1A;
         default: return 5'h1B;
      endcase
   endfunction

   always @(posedge CLK100MHZ) begin
      if (reset_in) begin
         m_run = 0; m_cyc = 0; m_free = 0; m_due = 0;
         m_pend = 0; m_prd = 0; m_pval = 0; m_cfg = 0;
         e_do = 0; e_drdy = 0; e_busy = 0; e_eoc = 0; e_ch = 0; e_err = 0;
         m_valid = 1'b1;
      end else begin
         m_acc = 1'b0;
         if (den_in) begin
            if (m_cyc >= m_free) begin
               m_acc  = 1'b1;
               m_pend = 1'b1;
               m_due  = m_cyc + LAT;
               m_free = m_due;
               m_prd  = !dwe_in;
               m_pval = model_reg(daddr_in, m_run, m_cfg);
            end else begin
               e_err = 1'b1;
            end
         end
         m_done = 1'b0;
         if (!m_cfg[0]) begin
            if (m_run % CONV == CONV - 1) begin
               m_done = 1'b1;
               e_ch   = model_chan((m_run / CONV) % 4);
            end
            m_run++;
         end
         e_eoc = m_done;
         if (m_acc && dwe_in && daddr_in == 7'h41) m_cfg = di_in;
         e_busy = !m_done && !m_cfg[0];
         e_drdy = m_pend && (m_due == m_cyc + 1);
         if (e_drdy) begin
            if (m_prd) e_do = m_pval;
            m_pend = 1'b0;
         end
         m_cyc++;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK100MHZ);
      t_cyc++;
      if (m_valid)
         check("cycle_model",
               {7'd0, do_out, drdy_out, busy_out, eoc_out, channel_out, drp_err_out},
               {7'd0, e_do, e_drdy, e_busy, e_eoc, e_ch, e_err});
   endtask

   task automatic do_reset();
      den_in = 0; dwe_in = 0; daddr_in = 0; di_in = 0;
      reset_in = 1;
      repeat (3) step();
      reset_in = 0;
      t_cyc = 0;
   endtask

   task automatic drp_issue(input logic [6:0] a, input logic we, input logic [15:0] d);
      daddr_in = a; dwe_in = we; di_in = d; den_in = 1;
      t_issue = t_cyc;
      step();
      den_in = 0; dwe_in = 0;
   endtask

   task automatic wait_drdy(output logic [15:0] val, output int lat);
      bit found = 0;
      val = 16'hxxxx; lat = -1;
      for (int i = 0; i < 20 && !found; i++) begin
         if (drdy_out) begin
            found = 1; val = do_out; lat = t_cyc - t_issue;
         end else begin
            step();
         end
      end
      check("drdy_seen", 32'(found), 32'd1);
   endtask

   task automatic wait_eoc(input int bound, output bit found);
      found = 0;
      for (int i = 0; i < bound && !found; i++) begin
         if (eoc_out) found = 1;
         else step();
      end
   endtask

   typedef struct {
      logic [6:0]  addr;
      logic        we;
      logic [15:0] wdata;
      logic [15:0] exp_do;
   } vec_t;

   vec_t        tbl [11];
   logic [6:0]  ch_tab [4];
   logic [15:0] val;
   int          lat, n1b, w_cyc;
   bit          found, quiet, no_drdy;

   initial begin
      reset_in = 1; den_in = 0; dwe_in = 0; daddr_in = 0; di_in = 0;
      ch_tab[0] = 7'h12; ch_tab[1] = 7'h13; ch_tab[2] = 7'h1A; ch_tab[3] = 7'h1B;
      // writes leave do_out at the previous read value
      tbl[0]  = '{7'h41, 1'b1, 16'h0001, 16'h0000};
      tbl[1]  = '{7'h12, 1'b0, 16'h0000, 16'h0000};
      tbl[2]  = '{7'h12, 1'b1, 16'hFFFF, 16'h0000};
      tbl[3]  = '{7'h12, 1'b0, 16'h0000, 16'h0000};
      tbl[4]  = '{7'h30, 1'b0, 16'h0000, 16'h0000};
      tbl[5]  = '{7'h41, 1'b0, 16'h0000, 16'h0001};
      tbl[6]  = '{7'h41, 1'b1, 16'hABCD, 16'h0001};
      tbl[7]  = '{7'h41, 1'b0, 16'h0000, 16'hABCD};
      tbl[8]  = '{7'h1B, 1'b0, 16'h0000, 16'h0000};
      tbl[9]  = '{7'h41, 1'b1, 16'h0000, 16'h0000};
      tbl[10] = '{7'h7F, 1'b0, 16'h0000, 16'h0000};

      // reset values, first eocs and channel order
      do_reset();
      check("reset_outputs", {7'd0, do_out, drdy_out, busy_out, eoc_out, channel_out, drp_err_out}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         wait_eoc(60, found);
         check("eoc_found", 32'(found), 32'd1);
         check("eoc_cycle", 32'(t_cyc), 32'(CONV * (k + 1)));
         check("eoc_chan", 32'(channel_out), 32'(ch_tab[k][4:0]));
         drp_issue(ch_tab[k], 1'b0, 16'h0);
         wait_drdy(val, lat);
         check("status_read", 32'(val), 32'(16'h0010 << k));
         check("drdy_latency", 32'(lat), 32'(LAT));
         if (k == 0) begin
            drp_issue(7'h12, 1'b1, 16'hFFFF);
            wait_drdy(val, lat);
            check("ro_write_do", 32'(val), 32'h0010);
            drp_issue(7'h12, 1'b0, 16'h0);
            wait_drdy(val, lat);
            check("ro_write_ignored", 32'(val), 32'h0010);
         end
      end

      // 512 full rounds: vaux11 wraps to zero
      do_reset();
      n1b = 0;
      for (int g = 0; g < 60000 && n1b < 512; g++) begin
         step();
         if (eoc_out && channel_out == 5'h1B) n1b++;
      end
      check("wrap_rounds", 32'(n1b), 32'd512);
      check("wrap_cycle", 32'(t_cyc), 32'(512 * 4 * CONV));
      drp_issue(7'h1B, 1'b0, 16'h0); wait_drdy(val, lat);
      check("wrap_1b", 32'(val), 32'h0000);
      drp_issue(7'h12, 1'b0, 16'h0); wait_drdy(val, lat);
      check("wrap_12", 32'(val), 32'h2000);
      drp_issue(7'h13, 1'b0, 16'h0); wait_drdy(val, lat);
      check("wrap_13", 32'(val), 32'h4000);

      // hold mid-conversion, then resume from the frozen count
      do_reset();
      while (t_cyc < 10) step();
      drp_issue(7'h41, 1'b1, 16'h0001);
      wait_drdy(val, lat);
      check("hold_busy", 32'(busy_out), 32'd0);
      drp_issue(7'h41, 1'b0, 16'h0); wait_drdy(val, lat);
      check("hold_cfg_read", 32'(val), 32'h0001);
      quiet = 1;
      repeat (200) begin
         step();
         if (busy_out || eoc_out) quiet = 0;
      end
      check("hold_quiet", 32'(quiet), 32'd1);
      w_cyc = t_cyc;
      drp_issue(7'h41, 1'b1, 16'h0000);
      wait_eoc(40, found);
      check("resume_eoc_found", 32'(found), 32'd1);
      check("resume_eoc_cycle", 32'(t_cyc), 32'(w_cyc + 16));
      check("resume_eoc_chan", 32'(channel_out), 32'h12);

      // protocol: early den is an error, den on the drdy cycle is accepted
      do_reset();
      repeat (3) step();
      daddr_in = 7'h13; dwe_in = 0; den_in = 1;
      step(); den_in = 0;                                     // t+1
      check("proto_err_t1", 32'(drp_err_out), 32'd0);
      step(); daddr_in = 7'h12; den_in = 1;                   // t+2
      step(); den_in = 0;                                     // t+3
      check("proto_err_t3", 32'(drp_err_out), 32'd1);
      check("proto_drdy_t3", 32'(drdy_out), 32'd0);
      step();                                                 // t+4
      check("proto_drdy_t4", 32'(drdy_out), 32'd1);
      daddr_in = 7'h1A; den_in = 1;
      step(); den_in = 0;                                     // t+5
      check("proto_drdy_t5", 32'(drdy_out), 32'd0);
      step(); step();                                         // t+7
      check("proto_drdy_t7", 32'(drdy_out), 32'd0);
      step();                                                 // t+8
      check("proto_drdy_t8", 32'(drdy_out), 32'd1);
      check("proto_err_sticky", 32'(drp_err_out), 32'd1);

      // register table
      do_reset();
      for (int i = 0; i < 11; i++) begin
         drp_issue(tbl[i].addr, tbl[i].we, tbl[i].wdata);
         wait_drdy(val, lat);
         check($sformatf("tbl_do_%0d", i), 32'(val), 32'(tbl[i].exp_do));
         check($sformatf("tbl_lat_%0d", i), 32'(lat), 32'(LAT));
      end

      // reset while a read is in flight
      drp_issue(7'h12, 1'b0, 16'h0);
      reset_in = 1;
      step();
      check("abort_outputs", {7'd0, do_out, drdy_out, busy_out, eoc_out, channel_out, drp_err_out}, 32'd0);
      reset_in = 0;
      no_drdy = 1;
      repeat (6) begin
         step();
         if (drdy_out) no_drdy = 0;
      end
      check("abort_no_drdy", 32'(no_drdy), 32'd1);

      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         reset_in = ($urandom_range(0, 599) == 0);
         den_in   = ($urandom_range(0, 3) == 0);
         dwe_in   = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 5))
            0: daddr_in = 7'h12;
            1: daddr_in = 7'h13;
            2: daddr_in = 7'h1A;
            3: daddr_in = 7'h1B;
            4: daddr_in = 7'h41;
            default: daddr_in = 7'($urandom);
         endcase
         di_in    = 16'($urandom);
         di_in[0] = ($urandom_range(0, 3) == 0);
         step();
      end
      reset_in = 0; den_in = 0; dwe_in = 0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
